// File: rtl/sub_16bit_seq_pkg.sv
// ============================================================================
// Module  : sub_16bit_seq_pkg
// Brief   : Shared FSM encoding and widths for the nibble-serial subtractor.
// Revision: 1.0
// ============================================================================
`default_nettype none

package sub_16bit_seq_pkg;

  localparam int NIBBLE_W  = 4;
  localparam int DEF_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/full_adder.sv
// ============================================================================
// Module  : full_adder
// Brief   : Single-bit full-adder cell.
// Revision: 1.0
// ============================================================================
`default_nettype none

module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);

  logic w_p;

  assign w_p    = i_a ^ i_b;
  assign o_s    = w_p ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & w_p);

endmodule

`default_nettype wire

// File: rtl/sub_4bit_step.sv
// ============================================================================
// Module  : sub_4bit_step
// Brief   : One nibble step of A + ~B + cin, rippled through full-adder cells.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sub_4bit_step
  import sub_16bit_seq_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b_inv,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout
);

  logic [NIBBLE_W:0] w_c;

  assign w_c[0] = cin;

  generate
    for (genvar gi = 0; gi < NIBBLE_W; gi++) begin : g_bit
      full_adder u_fa (
        .i_a    (a[gi]),
        .i_b    (b_inv[gi]),
        .i_cin  (w_c[gi]),
        .o_s    (s[gi]),
        .o_cout (w_c[gi+1])
      );
    end
  endgenerate

  assign cout = w_c[NIBBLE_W];

endmodule

`default_nettype wire

// File: rtl/sub_16bit_seq.sv
// ============================================================================
// Module  : sub_16bit_seq
// Brief   : Multi-cycle D = A - B, one nibble per clock LSB first, with flags.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sub_16bit_seq
  import sub_16bit_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             borrow,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int NSTEP = WIDTH / NIBBLE_W;
  localparam int CNT_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSTEP - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_carry;
  logic [WIDTH-1:0]    r_a;
  logic [WIDTH-1:0]    r_b_inv;
  logic [WIDTH-1:0]    r_d;
  logic                r_borrow;
  logic                r_zero;
  logic                r_neg;
  logic                r_ovf;

  logic [NIBBLE_W-1:0] w_a_nib;
  logic [NIBBLE_W-1:0] w_b_nib;
  logic [NIBBLE_W-1:0] w_sum;
  logic                w_cout;
  logic [WIDTH-1:0]    w_d_nxt;
  logic                w_accept;
  logic                w_last;

  // Select the active nibble and build D with that nibble replaced by the step sum.
  always_comb begin
    w_a_nib = '0;
    w_b_nib = '0;
    w_d_nxt = r_d;
    for (int i = 0; i < NSTEP; i++) begin
      if (r_cnt == CNT_W'(i)) begin
        w_a_nib = r_a[i*NIBBLE_W +: NIBBLE_W];
        w_b_nib = r_b_inv[i*NIBBLE_W +: NIBBLE_W];
        w_d_nxt[i*NIBBLE_W +: NIBBLE_W] = w_sum;
      end
    end
  end

  sub_4bit_step u_step (
    .a     (w_a_nib),
    .b_inv (w_b_nib),
    .cin   (r_carry),
    .s     (w_sum),
    .cout  (w_cout)
  );

  assign w_accept = in_valid && (r_state == ST_IDLE);
  assign w_last   = (r_state == ST_CALC) && (r_cnt == LAST_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = ST_CALC;
      end
      ST_CALC: begin
        if (r_cnt == LAST_CNT) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_carry  <= 1'b1;
      r_a      <= '0;
      r_b_inv  <= '0;
      r_d      <= '0;
      r_borrow <= 1'b0;
      r_zero   <= 1'b0;
      r_neg    <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_a      <= A;
      r_b_inv  <= ~B;
      r_carry  <= 1'b1;
      r_cnt    <= '0;
      r_d      <= '0;
      r_borrow <= 1'b0;
      r_zero   <= 1'b0;
      r_neg    <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (r_state == ST_CALC) begin
      r_d     <= w_d_nxt;
      r_carry <= w_cout;
      r_cnt   <= w_last ? '0 : r_cnt + CNT_W'(1);
      if (w_last) begin
        // B's sign is recovered from the stored inverted operand.
        r_borrow <= ~w_cout;
        r_zero   <= (w_d_nxt == '0);
        r_neg    <= w_d_nxt[WIDTH-1];
        r_ovf    <= (r_a[WIDTH-1] == r_b_inv[WIDTH-1]) &&
                    (w_d_nxt[WIDTH-1] != r_a[WIDTH-1]);
      end
    end
  end

  assign D      = r_d;
  assign borrow = r_borrow;
  assign zero   = r_zero;
  assign neg    = r_neg;
  assign ovf    = r_ovf;

endmodule

`default_nettype wire

// File: doc/sub_16bit_seq.md
Name: sub_16bit_seq

Overview:
Multi-cycle 16-bit subtractor with status flags. It computes D = A - B one 4-bit nibble per clock, least significant nibble first, using two's-complement addition (A + ~B + 1).
It is the inverse-operation companion to the 16-bit flagged adder datapath. It sits behind a valid/ready operand interface and presents its result on a valid/ready result interface.

Parameters:
WIDTH, 16, operand/result width; must be a multiple of 4 (WIDTH/4 nibble steps)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  operand pair A/B presented
in_ready  output  1  block can accept operands (high only in IDLE)
A  input  WIDTH  minuend
B  input  WIDTH  subtrahend
out_valid  output  1  D and flags valid
out_ready  input  1  consumer accepts result
D  output  WIDTH  difference A - B (mod 2^WIDTH)
borrow  output  1  1 when A < B unsigned (inverse of final carry)
zero  output  1  D == 0
neg  output  1  D[WIDTH-1]
ovf  output  1  signed overflow

Behaviour:
- Reset, asynchronous on rst high:
  - state=IDLE, nibble counter=0, carry reg=1.
  - Operand regs, D, borrow, zero, neg, ovf, out_valid all 0; in_ready=1 after reset deasserts.
- Reset mid-operation aborts the computation. No partial result is ever presented.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at a clock edge: latch A and ~B into operand regs, set carry reg=1 and cnt=0, clear D, go to CALC.
- CALC:
  - in_ready=0.
  - Each cycle, add nibble cnt of A, nibble cnt of ~B and carry reg.
  - Write the 4-bit sum into D[4*cnt+3:4*cnt] and the nibble carry-out into carry reg.
  - cnt increments. When cnt == WIDTH/4-1, go to DONE.
- Latency: out_valid rises exactly WIDTH/4 cycles after the accepting edge, i.e. 4 cycles at default.
- DONE:
  - out_valid=1. D and all flags are stable while out_valid=1.
  - On out_ready high at an edge: out_valid drops and state goes to IDLE.
  - Operands cannot be accepted in the same cycle as the result handoff; in_ready rises the cycle after.
- Flags are registered on the CALC to DONE transition:
  - borrow = ~final carry.
  - zero = (final D == 0).
  - neg = final D MSB.
  - ovf = (A[MSB] != B[MSB]) && (D[MSB] != A[MSB]), using the latched operands.
- Back-pressure: out_ready low holds DONE indefinitely with no output change.
- in_valid is ignored outside IDLE. Changes on A/B after acceptance have no effect.
- Arithmetic is modulo 2^WIDTH. No saturation.

Decomposition:
- Shared package holds:
  - FSM state encoding constants (IDLE=2'd0, CALC=2'd1, DONE=2'd2).
  - NIBBLE_W=4.
  - The default WIDTH.
- One combinational sub-module, sub_4bit_step: 4-bit a, 4-bit b_inv, cin in; 4-bit s and cout out. It is ripple-built from the existing full-adder cell.
- The top module holds the FSM, counter, operand/result registers and flag logic.

Test Plan:
- Reset then A=0x1234, B=0x0234 -> out_valid at edge 4 after accept; D=0x1000, borrow=0, zero=0, neg=0, ovf=0.
- A=0x0000, B=0x0001 -> D=0xFFFF, borrow=1, neg=1, zero=0, ovf=0.
- A=0x8000, B=0x0001 -> D=0x7FFF, ovf=1, neg=0, borrow=0; then A=0x7FFF, B=0xFFFF -> D=0x8000, ovf=1, borrow=1.
- A=0x5A5A, B=0x5A5A -> D=0x0000, zero=1, borrow=0; hold out_ready=0 for 10 cycles -> outputs stable, in_ready=0 throughout.
- Assert rst during CALC (cycle 2 after accept) -> all outputs 0 immediately, in_ready=1 after release; next op A=0x0010, B=0x0001 -> D=0x000F.
- Back-to-back: in_valid held high with out_ready=1 -> one result every 6 cycles, in_valid ignored outside IDLE, no operand lost or duplicated.
